aes_byte_stream_io: RTL

- Byte-serial front/back end for the combinational AES-128 encrypt core on the 8-bit-pin tile.
- Upstream side: assembles a 16-byte key and a 16-byte plaintext from an 8-bit input port, then drives them to the core as 128-bit words.
- Downstream side: waits for the core to settle, captures the 128-bit result, and streams it out one byte at a time.
- Key persists across blocks until it is reloaded.

---
 rtl/aes_io_pkg.sv | 14 +
 rtl/aes_byte_shifter.sv | 34 +++
 rtl/aes_byte_stream_io.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/aes_io_pkg.sv
// Shared widths, counter size and FSM state encoding for the AES byte-stream I/O block.
package aes_io_pkg;
  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    UNLOAD  = 2'd3
  } state_e;
endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit register that can be parallel-loaded or shifted left one byte with a new low byte.
module aes_byte_shifter
  import aes_io_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_val,
  input  logic               shift,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [BLOCK_W-1:0] q
);
  logic [BLOCK_W-1:0] reg_q, reg_d;

  always_comb begin
    reg_d = reg_q;
    if (load) begin
      reg_d = load_val;
    end else if (shift) begin
      reg_d = {reg_q[BLOCK_W-BYTE_W-1:0], byte_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
    end else if (en) begin
      reg_q <= reg_d;
    end
  end

  assign q = reg_q;
endmodule

// File: rtl/aes_byte_stream_io.sv
// Byte-serial key/plaintext loader and ciphertext streamer around a combinational AES-128 core.
// Optional macro AES_DECRYPT_CHECK_EN adds a decrypt-path comparator with sticky check_err.
module aes_byte_stream_io
  import aes_io_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [BYTE_W-1:0]  in_byte,
  input  logic               in_valid,
  input  logic               in_is_key,
  output logic               in_ready,
  output logic [BYTE_W-1:0]  out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               key_loaded,
  output logic               busy,
  output logic [BLOCK_W-1:0] core_key_o,
  output logic [BLOCK_W-1:0] core_data_o,
  input  logic [BLOCK_W-1:0] core_result_i
`ifdef AES_DECRYPT_CHECK_EN
  ,
  input  logic [BLOCK_W-1:0] core_check_i,
  output logic               check_err
`endif
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             key_loaded_q, key_loaded_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             key_shift, data_shift, res_load, res_shift;
  logic             in_hs, out_hs;
  logic [BLOCK_W-1:0] result_q;
  logic             unused_result;

  assign in_ready  = (state_q == LOAD) && ena &&
                     (in_is_key ? (data_cnt_q == '0) : key_loaded_q);
  assign out_valid = out_valid_q && ena;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Next-state, counters and shifter controls
  always_comb begin
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    data_cnt_d   = data_cnt_q;
    out_cnt_d    = out_cnt_q;
    settle_cnt_d = settle_cnt_q;
    key_loaded_d = key_loaded_q;
    out_valid_d  = 1'b0;
    key_shift    = 1'b0;
    data_shift   = 1'b0;
    res_load     = 1'b0;
    res_shift    = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_hs && in_is_key) begin
          key_shift = 1'b1;
          key_cnt_d = key_cnt_q + CNT_W'(1);
          if (key_cnt_q == '0)             key_loaded_d = 1'b0;
          if (key_cnt_q == CNT_W'(15))     key_loaded_d = 1'b1;
        end else if (in_hs) begin
          data_shift = 1'b1;
          data_cnt_d = data_cnt_q + CNT_W'(1);
          if (data_cnt_q == CNT_W'(15)) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d      = CAPTURE;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        res_load   = 1'b1;
        data_cnt_d = '0;
        out_cnt_d  = '0;
        state_d    = UNLOAD;
      end
      UNLOAD: begin
        out_valid_d = 1'b1;
        if (out_hs) begin
          res_shift = 1'b1;
          out_cnt_d = out_cnt_q + CNT_W'(1);
          if (out_cnt_q == CNT_W'(15)) begin
            out_valid_d = 1'b0;
            state_d     = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    busy_d = (state_d != LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      key_cnt_q    <= '0;
      data_cnt_q   <= '0;
      out_cnt_q    <= '0;
      settle_cnt_q <= '0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      data_cnt_q   <= data_cnt_d;
      out_cnt_q    <= out_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  aes_byte_shifter u_key (
    .clk(clk), .rst_n(rst_n), .en(ena), .load(1'b0), .load_val('0),
    .shift(key_shift), .byte_in(in_byte), .q(core_key_o)
  );

  aes_byte_shifter u_data (
    .clk(clk), .rst_n(rst_n), .en(ena), .load(1'b0), .load_val('0),
    .shift(data_shift), .byte_in(in_byte), .q(core_data_o)
  );

  aes_byte_shifter u_result (
    .clk(clk), .rst_n(rst_n), .en(ena), .load(res_load), .load_val(core_result_i),
    .shift(res_shift), .byte_in('0), .q(result_q)
  );

  // Only the top byte of the result leaves the block; the rest just feeds the shift.
  assign unused_result = ^result_q[BLOCK_W-BYTE_W-1:0];
  assign out_byte      = result_q[BLOCK_W-1 -: BYTE_W];
  assign key_loaded    = key_loaded_q;
  assign busy          = busy_q;

`ifdef AES_DECRYPT_CHECK_EN
  logic chk_pend_q, chk_pend_d;
  logic check_err_q, check_err_d;

  // Compare decrypt output with the held plaintext on the first UNLOAD cycle
  always_comb begin
    chk_pend_d  = (state_q == CAPTURE);
    check_err_d = check_err_q;
    if (chk_pend_q && (core_check_i != core_data_o)) check_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_pend_q  <= 1'b0;
      check_err_q <= 1'b0;
    end else if (ena) begin
      chk_pend_q  <= chk_pend_d;
      check_err_q <= check_err_d;
    end
  end

  assign check_err = check_err_q;
`endif
endmodule
